// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, error codes and
// the keyboard command bytes the rest of the system sends.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, WAIT_DEV, SHIFT, STOP, ACK, WAIT_IDLE
    } ps2TxState_t;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_XFER_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_NO_ACK        = 2'b11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // PS/2 frames carry odd parity over the data byte
    function automatic logic oddParity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the raw PS2_CLK/PS2_DAT pins plus falling-edge
// detect on the clock line; shared between the PS/2 receive and transmit paths.
module ps2_line_sync (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic ps2ClkIn,
    input  logic ps2DatIn,
    output logic clkSync,
    output logic datSync,
    output logic clkFall
);

    logic clkMeta, datMeta, clkPrev;

    // Preset to 1 so an idle (released) bus never shows a spurious edge out of reset
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clkMeta <= 1'b1;
            clkSync <= 1'b1;
            clkPrev <= 1'b1;
            datMeta <= 1'b1;
            datSync <= 1'b1;
        end else begin
            clkMeta <= ps2ClkIn;
            clkSync <= clkMeta;
            clkPrev <= clkSync;
            datMeta <= ps2DatIn;
            datSync <= datMeta;
        end
    end

    assign clkFall = clkPrev & ~clkSync;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data
// bits, odd parity, stop and device ACK, with start and transfer timeouts.
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int CNT_W          = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       send_valid,
    input  logic [7:0] cmd_byte,
    output logic       send_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    ps2TxState_t      state;
    logic [CNT_W-1:0] timer;
    logic [7:0]       shiftByte;
    logic             parityBit;
    logic [3:0]       bitIdx;
    logic             datOe;
    logic             clkSync, datSync, clkFall;
    logic             inXfer;

    ps2_line_sync uSync (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .ps2ClkIn (ps2_clk_in),
        .ps2DatIn (ps2_dat_in),
        .clkSync  (clkSync),
        .datSync  (datSync),
        .clkFall  (clkFall)
    );

    // The transfer timer spans everything after the device's first clock edge
    assign inXfer = (state == SHIFT) || (state == STOP) || (state == ACK) || (state == WAIT_IDLE);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            timer     <= '0;
            shiftByte <= '0;
            parityBit <= 1'b0;
            bitIdx    <= '0;
            datOe     <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (inXfer && timer == CNT_W'(XFER_TIMEOUT - 1)) begin
                state    <= IDLE;
                datOe    <= 1'b0;
                error    <= 1'b1;
                err_code <= ERR_XFER_TIMEOUT;
            end else begin
                if (inXfer) timer <= timer + 1'b1;
                case (state)
                    IDLE: if (send_valid) begin
                        shiftByte <= cmd_byte;
                        parityBit <= oddParity(cmd_byte);
                        err_code  <= ERR_NONE;
                        timer     <= '0;
                        state     <= INHIBIT;
                    end
                    INHIBIT: if (timer == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        datOe <= 1'b1;
                        state <= RTS;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    RTS: begin
                        timer <= '0;
                        state <= WAIT_DEV;
                    end
                    WAIT_DEV: if (timer == CNT_W'(START_TIMEOUT - 1)) begin
                        datOe    <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_START_TIMEOUT;
                        state    <= IDLE;
                    end else if (clkFall) begin
                        datOe  <= ~shiftByte[0];
                        bitIdx <= 4'd1;
                        timer  <= '0;
                        state  <= SHIFT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    SHIFT: if (clkFall) begin
                        if (bitIdx == 4'd8) begin
                            datOe <= ~parityBit;
                            state <= STOP;
                        end else begin
                            datOe  <= ~shiftByte[bitIdx[2:0]];
                            bitIdx <= bitIdx + 4'd1;
                        end
                    end
                    STOP: if (clkFall) begin
                        datOe <= 1'b0;
                        state <= ACK;
                    end
                    ACK: if (clkFall) begin
                        if (!datSync) begin
                            state <= WAIT_IDLE;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_NO_ACK;
                            state    <= IDLE;
                        end
                    end
                    WAIT_IDLE: if (clkSync && datSync) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign send_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign ps2_clk_oe = (state == INHIBIT) || (state == RTS);
    assign ps2_dat_oe = datOe;

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx: an open-drain bus model with a PS/2
// device that clocks in the frame, plus a frame reference built from the byte.
module tb_ps2_command_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int ST  = 400;
    localparam int XF  = 1500;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       send_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       send_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic [1:0] err_code;
    logic       devClkLow = 1'b0, devDatLow = 1'b0;
    wire        clkLine = !(ps2_clk_oe || devClkLow);
    wire        datLine = !(ps2_dat_oe || devDatLow);
    int         checks = 0, errors = 0, cyc = 0;

    ps2_command_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .XFER_TIMEOUT(XF), .CNT_W(12)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .send_valid(send_valid), .cmd_byte(cmd_byte),
        .send_ready(send_ready), .ps2_clk_in(clkLine), .ps2_dat_in(datLine),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy), .done(done),
        .error(error), .err_code(err_code)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference frame as the device sees it: {stop, parity, data LSB first}
    function automatic logic [9:0] expFrame(input logic [7:0] c);
        logic par;
        par = ($countones(c) % 2 == 0);
        return {1'b1, par, c};
    endfunction

    task automatic sendCmd(input logic [7:0] c);
        send_valid = 1'b1;
        cmd_byte   = c;
        @(negedge CLOCK_50);
        send_valid = 1'b0;
        cmd_byte   = 8'($urandom);
    endtask

    // Device side: wait for request-to-send, then generate 'edges' clock pulses
    task automatic devRun(input int edges, input bit ack, input int half,
                          output logic [9:0] got, output int tFirst);
        int n;
        got = '0;
        tFirst = 0;
        n = 0;
        while (!(clkLine && !datLine) && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL dev_rts_wait: no request-to-send within %0d cycles", n);
            return;
        end
        repeat (half) @(negedge CLOCK_50);
        for (int i = 0; i < edges; i++) begin
            devClkLow = 1'b1;
            if (i == 0) tFirst = cyc;
            repeat (half) @(negedge CLOCK_50);
            if (i < 10) got[i] = datLine;
            devClkLow = 1'b0;
            if (i == 9 && ack) devDatLow = 1'b1;
            repeat (half) @(negedge CLOCK_50);
        end
        devDatLow = 1'b0;
    endtask

    task automatic waitResult(input int bound, output bit d, output bit e, output int tEnd, output bit prevBusy);
        d = 0; e = 0; prevBusy = busy; tEnd = cyc;
        for (int n = 0; n < bound; n++) begin
            prevBusy = busy;
            @(negedge CLOCK_50);
            if (done || error) begin
                d = done; e = error; tEnd = cyc;
                return;
            end
        end
        tEnd = cyc;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", send_ready); end
        resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_set_led();
        logic [9:0] got; int tFirst, tEnd, inh; bit d, e, pb;
        sendCmd(CMD_SET_LED);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL led_busy: got %b expected 1", busy); end
        fork
            devRun(11, 1, 10, got, tFirst);
            begin
                inh = 0;
                while (ps2_clk_oe && !ps2_dat_oe && inh < INH + 10) begin
                    inh++;
                    @(negedge CLOCK_50);
                end
                checks++; if (inh != INH) begin errors++; $display("FAIL led_inhibit_len: got %0d expected %0d", inh, INH); end
                checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b11) begin errors++; $display("FAIL led_rts: got %b expected 11", {ps2_clk_oe, ps2_dat_oe}); end
                waitResult(4000, d, e, tEnd, pb);
            end
        join
        checks++; if (got !== expFrame(CMD_SET_LED)) begin errors++; $display("FAIL led_frame: got %b expected %b", got, expFrame(CMD_SET_LED)); end
        checks++; if ({d, e} !== 2'b10) begin errors++; $display("FAIL led_done: got done/error %b expected 10", {d, e}); end
        checks++; if (err_code !== ERR_NONE) begin errors++; $display("FAIL led_err_code: got %b expected 00", err_code); end
        checks++; if ({pb, busy, send_ready} !== 3'b101) begin errors++; $display("FAIL led_busy_drop: got %b expected 101", {pb, busy, send_ready}); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got; int tFirst, tEnd; bit d, e, pb;
        sendCmd(CMD_ENABLE);
        fork
            devRun(11, 1, 10, got, tFirst);
            waitResult(4000, d, e, tEnd, pb);
        join
        checks++; if (got !== expFrame(CMD_ENABLE)) begin errors++; $display("FAIL f4_frame: got %b expected %b", got, expFrame(CMD_ENABLE)); end
        checks++; if ({d, e, send_ready} !== 3'b101) begin errors++; $display("FAIL f4_done: got done/error/ready %b expected 101", {d, e, send_ready}); end
        send_valid = 1'b1;
        cmd_byte   = CMD_RESET;
        @(negedge CLOCK_50);
        checks++; if ({busy, ps2_clk_oe, ps2_dat_oe} !== 3'b110) begin errors++; $display("FAIL b2b_accept: got %b expected 110", {busy, ps2_clk_oe, ps2_dat_oe}); end
        // Requests while busy must be ignored, including a changing byte
        for (int i = 0; i < 3; i++) begin
            cmd_byte = 8'($urandom);
            @(negedge CLOCK_50);
        end
        send_valid = 1'b0;
        fork
            devRun(11, 1, 10, got, tFirst);
            waitResult(4000, d, e, tEnd, pb);
        join
        checks++; if (got !== expFrame(CMD_RESET)) begin errors++; $display("FAIL ff_frame: got %b expected %b", got, expFrame(CMD_RESET)); end
        checks++; if ({d, e} !== 2'b10) begin errors++; $display("FAIL ff_done: got %b expected 10", {d, e}); end
    endtask

    task automatic test_start_timeout();
        int n, k;
        sendCmd(8'($urandom));
        n = 0;
        while (!(ps2_clk_oe && ps2_dat_oe) && n < INH + 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        @(negedge CLOCK_50);
        k = 0;
        while (!error && !done && k < ST + 20) begin
            @(negedge CLOCK_50);
            k++;
        end
        checks++; if ({error, done} !== 2'b10) begin errors++; $display("FAIL st_pulse: got error/done %b expected 10", {error, done}); end
        checks++; if (k != ST) begin errors++; $display("FAIL st_latency: got %0d expected %0d", k, ST); end
        checks++; if (err_code !== ERR_START_TIMEOUT) begin errors++; $display("FAIL st_code: got %b expected 01", err_code); end
        checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin errors++; $display("FAIL st_release: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
        @(negedge CLOCK_50);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL st_one_cycle: got %b expected 0", error); end
    endtask

    task automatic test_no_ack();
        logic [9:0] got; logic [7:0] c; int tFirst, tEnd; bit d, e, pb;
        c = 8'($urandom);
        sendCmd(c);
        fork
            devRun(11, 0, 10, got, tFirst);
            waitResult(4000, d, e, tEnd, pb);
        join
        checks++; if (got !== expFrame(c)) begin errors++; $display("FAIL noack_frame: got %b expected %b", got, expFrame(c)); end
        checks++; if ({d, e} !== 2'b01) begin errors++; $display("FAIL noack_pulse: got done/error %b expected 01", {d, e}); end
        checks++; if (err_code !== ERR_NO_ACK) begin errors++; $display("FAIL noack_code: got %b expected 11", err_code); end
    endtask

    task automatic test_random();
        logic [9:0] got; logic [7:0] c; int tFirst, tEnd, half; bit d, e, pb;
        for (int it = 0; it < 4; it++) begin
            c = 8'($urandom);
            half = $urandom_range(6, 14);
            sendCmd(c);
            checks++; if (err_code !== ERR_NONE) begin errors++; $display("FAIL rnd_code_clear: got %b expected 00", err_code); end
            fork
                devRun(11, 1, half, got, tFirst);
                waitResult(4000, d, e, tEnd, pb);
            join
            checks++; if (got !== expFrame(c)) begin errors++; $display("FAIL rnd_frame %02h: got %b expected %b", c, got, expFrame(c)); end
            checks++; if ({d, e} !== 2'b10) begin errors++; $display("FAIL rnd_done %02h: got %b expected 10", c, {d, e}); end
        end
    endtask

    task automatic test_xfer_timeout();
        logic [9:0] got; logic [7:0] c; int tFirst, tEnd, dt; bit d, e, pb;
        c = 8'($urandom);
        sendCmd(c);
        fork
            devRun(4, 1, 10, got, tFirst);
            waitResult(XF + 2000, d, e, tEnd, pb);
        join
        dt = tEnd - tFirst;
        checks++; if (got[3:0] !== c[3:0]) begin errors++; $display("FAIL xf_bits: got %b expected %b", got[3:0], c[3:0]); end
        checks++; if ({d, e} !== 2'b01) begin errors++; $display("FAIL xf_pulse: got done/error %b expected 01", {d, e}); end
        checks++; if (err_code !== ERR_XFER_TIMEOUT) begin errors++; $display("FAIL xf_code: got %b expected 10", err_code); end
        checks++; if (dt < XF || dt > XF + 6) begin errors++; $display("FAIL xf_latency: got %0d expected %0d..%0d", dt, XF, XF + 6); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got; int tFirst; bit seen;
        sendCmd(8'h00);
        devRun(4, 1, 10, got, tFirst);
        checks++; if ({busy, ps2_dat_oe} !== 2'b11) begin errors++; $display("FAIL rst_pre: got %b expected 11", {busy, ps2_dat_oe}); end
        #2 resetn = 1'b0;
        #1;
        checks++; if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy}); end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (done || error || busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_quiet: got activity %b expected 0", seen); end
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", send_ready); end
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_back_to_back();
        test_start_timeout();
        test_no_ack();
        test_random();
        test_xfer_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
